residual_add_buffer: RTL and testbench
======================================

// Module: residual_add_buffer
// PURPOSE
//   Transformer residual join, directly upstream of the layer-norm stage.
//   - Accepts a row-major stream of element pairs (sublayer output a, skip b).
//   - Computes the saturating signed sum a+b and collects it into a full
//     SEQ_LEN x EMB_DIM matrix.
//   - Presents the matrix as one flattened word, with a one-cycle start pulse
//     that launches layer norm.
// PARAMETERS
//   DATA_WIDTH  16  element width, signed two's complement
//   SEQ_LEN     8   rows (tokens) per matrix
//   EMB_DIM     8   columns (embedding dim) per row
//   N = SEQ_LEN*EMB_DIM (localparam, elements per matrix)
// PORTS
//   clk        in   1              clock, all state on rising edge
//   rst_n      in   1              reset, asynchronous, active-low
//   in_valid   in   1              input pair valid
//   in_ready   out  1              block can accept a pair
//   in_a       in   DATA_WIDTH     sublayer output element, signed
//   in_b       in   DATA_WIDTH     residual (skip) element, signed
//   out_valid  out  1              x_out holds a complete matrix
//   out_ready  in   1              consumer has taken x_out
//   ln_start   out  1              1-cycle pulse, same cycle out_valid rises
//   x_out      out  DATA_WIDTH*N   flattened sums; elem (r,c) at bits [(r*EMB_DIM+c)*DATA_WIDTH +: DATA_WIDTH]
//   sat_count  out  $clog2(N+1)    number of elements clipped in the current matrix
// BEHAVIOUR
//   Reset (async): state=S_FILL, idx=0, in_ready=1, out_valid=0, ln_start=0,
//     x_out=0, sat_count=0.
//   Input handshake:
//     - A beat transfers when in_valid && in_ready.
//     - in_ready = (state==S_FILL), registered, with no combinational path
//       from in_valid.
//     - Upstream holds in_a and in_b stable while in_valid && !in_ready.
//   Arithmetic:
//     - sum = sext(a)+sext(b) at DATA_WIDTH+1 bits.
//     - If sum > 2^(DW-1)-1 the result is 2^(DW-1)-1 (32767).
//     - If sum < -2^(DW-1) the result is -2^(DW-1) (-32768).
//     - Otherwise the result is sum[DW-1:0].
//     - Every clipped element increments sat_count, which saturates at N.
//   Write: the accepted beat k (0..N-1) writes element k of x_out, i.e.
//     row k/EMB_DIM, col k%EMB_DIM.
//   FSM:
//     S_FILL: on each accepted beat, idx++.
//       - If the accepted beat has idx==N-1: go to S_HOLD, set idx=0, and set
//         out_valid=1 and ln_start=1 on the next edge.
//     S_HOLD: in_ready=0; x_out and sat_count stay frozen.
//       - ln_start is deasserted after one cycle.
//       - On out_valid && out_ready: go to S_FILL, out_valid=0, sat_count=0,
//         in_ready=1 next cycle.
//   Latency: the last beat accepted at edge t gives out_valid=1 and a
//     complete x_out after edge t.
//   Throughput:
//     - One beat per cycle in S_FILL.
//     - Minimum one idle input cycle per matrix: from the cycle after the
//       last beat until the cycle after the out handshake.
//   Boundaries:
//     - An in_valid gap during fill holds idx; there is no timeout.
//     - in_valid in S_HOLD is ignored and not consumed.
//     - out_ready asserted in S_FILL has no effect.
//     - out_ready held high in S_HOLD completes the handshake in the first
//       S_HOLD cycle. ln_start is still a clean one-cycle pulse.
//     - Elements of x_out not yet rewritten during a fill keep the previous
//       matrix values. They are only meaningful while out_valid=1.
//     - rst_n low mid-fill or mid-hold: the partial matrix is discarded, all
//       outputs return to reset values, and a fresh fill starts from idx 0.
//   x_out is stable from the out_valid rise until the handshake. It may be
//     wired straight to the layer-norm x_in, with ln_start driving its start.
// TESTING
//   1. Ramp: a=k, b=100 for k=0..63, in_valid continuous.
//      -> in_ready stays 1 for 64 cycles.
//      -> out_valid and ln_start rise 1 cycle after beat 63; ln_start lasts
//         exactly 1 cycle.
//      -> elem(r,c)=8r+c+100; sat_count=0.
//   2. Saturation: beat0 a=30000,b=30000; beat1 a=-30000,b=-30000;
//      beat2 a=32767,b=-1; remaining beats 0+0.
//      -> elem0=32767, elem1=-32768, elem2=32766; sat_count=2.
//   3. Backpressure: complete a matrix with out_ready=0 for 10 cycles, then
//      present a new in_valid beat.
//      -> in_ready=0 and x_out frozen for the 10 cycles.
//      -> on out_ready=1 the handshake occurs and in_ready=1 the next cycle.
//      -> the next beat lands in elem0 and sat_count restarts at 0.
//   4. Bursty input: in_valid toggles 1,0,1,0 (random gaps) over 64 beats.
//      -> exactly 64 elements written in order.
//      -> out_valid only after the 64th accepted beat.
//   5. Reset mid-fill: assert rst_n=0 after 20 beats, release, then send 64
//      beats a=1,b=1.
//      -> all outputs at reset values during reset.
//      -> the final matrix is all 2 with no stale data; sat_count=0.
//   6. Back-to-back with a layer-norm model: two matrices, out_ready tied to
//      the model's done signal.
//      -> each ln_start gives exactly one LN run.
//      -> no input beat is lost or duplicated across the matrix boundary.

Source files
------------

// File: rtl/residual_add_buffer.sv
// Residual join: saturating a+b per beat, collected into a SEQ_LEN x EMB_DIM matrix; launches layer norm.
// Latency: out_valid/ln_start rise the edge after the last beat. Backpressure: in_ready low while a matrix waits for out_ready.
module residual_add_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 8,
    parameter int EMB_DIM    = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [DATA_WIDTH-1:0]                    in_a,
    input  logic [DATA_WIDTH-1:0]                    in_b,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     ln_start,
    output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0]    x_out,
    output logic [$clog2(SEQ_LEN*EMB_DIM+1)-1:0]     sat_count
);
    localparam int N  = SEQ_LEN * EMB_DIM;
    localparam int IW = $clog2(N);
    localparam int SW = $clog2(N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [SW-1:0] SAT_MAX  = SW'(N);

    typedef enum logic {S_FILL, S_HOLD} state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         idx;
    logic                  accept, last_beat, take;
    logic [DATA_WIDTH:0]   sum;
    logic                  clip;
    logic [DATA_WIDTH-1:0] sat_val;

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (idx == LAST_IDX);
    assign take      = out_valid && out_ready;

    // One guard bit: overflow shows up as the top two sum bits disagreeing.
    always_comb begin
        sum  = {in_a[DATA_WIDTH-1], in_a} + {in_b[DATA_WIDTH-1], in_b};
        clip = sum[DATA_WIDTH] != sum[DATA_WIDTH-1];
        if (!clip)
            sat_val = sum[DATA_WIDTH-1:0];
        else if (sum[DATA_WIDTH])
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: if (last_beat) state_nxt = S_HOLD;
            S_HOLD: if (take)      state_nxt = S_FILL;
            default:               state_nxt = S_FILL;
        endcase
    end

    // Handshake outputs are flops fed from next-state, so in_ready never depends on in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ln_start  <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == S_FILL);
            out_valid <= (state_nxt == S_HOLD);
            ln_start  <= last_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            x_out     <= '0;
            sat_count <= '0;
        end else if (accept) begin
            x_out[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= sat_val;
            idx <= last_beat ? '0 : idx + IW'(1);
            if (clip && sat_count != SAT_MAX)
                sat_count <= sat_count + SW'(1);
        end else if (take) begin
            sat_count <= '0;
        end
    end
endmodule

// File: tb/tb_residual_add_buffer.sv
// Bench for residual_add_buffer: random and directed traffic checked every cycle against a matrix-level model.
module tb_residual_add_buffer;
    localparam int DW = 16;
    localparam int N  = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_a = '0;
    logic [DW-1:0]   in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            ln_start;
    logic [DW*N-1:0] x_out;
    logic [6:0]      sat_count;

    residual_add_buffer #(.DATA_WIDTH(DW), .SEQ_LEN(8), .EMB_DIM(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .ln_start(ln_start), .x_out(x_out), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clip(input int s);
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic int elem(input int k);
        logic signed [DW-1:0] e;
        e = x_out[k*DW +: DW];
        return int'(e);
    endfunction

    // Matrix-level model: a list of written values, a count of beats, and whether a full matrix is waiting.
    int m_mat [N];
    int m_cnt, m_sat;
    bit m_hold, m_ln;

    always @(posedge clk or negedge rst_n) begin
        int s, v;
        if (!rst_n) begin
            m_cnt = 0; m_sat = 0; m_hold = 0; m_ln = 0;
            foreach (m_mat[i]) m_mat[i] = 0;
        end else begin
            m_ln = 0;
            if (!m_hold) begin
                if (in_valid) begin
                    s = int'($signed(in_a)) + int'($signed(in_b));
                    v = clip(s);
                    m_mat[m_cnt] = v;
                    if (v != s && m_sat < N) m_sat++;
                    m_cnt++;
                    if (m_cnt == N) begin
                        m_cnt = 0; m_hold = 1; m_ln = 1;
                    end
                end
            end else if (out_ready) begin
                m_hold = 0; m_sat = 0;
            end
        end
    end

    always @(negedge clk) begin
        int first_bad;
        check("in_ready", in_ready, !m_hold);
        check("out_valid", out_valid, m_hold);
        check("ln_start", ln_start, m_ln);
        check("sat_count", sat_count, m_sat);
        first_bad = -1;
        for (int k = N - 1; k >= 0; k--)
            if (elem(k) != m_mat[k]) first_bad = k;
        if (first_bad >= 0)
            check($sformatf("x_out_elem%0d", first_bad), 64'(elem(first_bad)), 64'(m_mat[first_bad]));
        else
            check("x_out", 0, 0);
    end

    // Layer-norm stand-in: each ln_start runs for a few cycles, then pulses done as out_ready.
    bit use_ln = 0;
    int ln_busy = 0;
    int ln_runs = 0;
    initial forever begin
        @(posedge clk); #1;
        if (use_ln) begin
            out_ready = 1'b0;
            if (ln_start) begin
                check("ln_start_while_busy", ln_busy, 0);
                ln_runs++;
                ln_busy = 4;
            end else if (ln_busy > 0) begin
                ln_busy--;
                if (ln_busy == 0) out_ready = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input int a, input int b, input int gap_max);
        int g, t;
        bit acc;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            step();
        end
        in_valid = 1'b1;
        in_a = 16'(a);
        in_b = 16'(b);
        t = 0;
        do begin
            acc = in_ready;
            step();
            t++;
        end while (!acc && t < 300);
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic take();
        int t;
        out_ready = 1'b1;
        t = 0;
        do begin step(); t++; end while (out_valid && t < 50);
        check("take_timeout", out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        int c0, nerr;
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, nerr, t;
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_x_out", |x_out, 0);
        rst_n = 1'b1;
        step();

        // Ramp, continuous input
        c0 = cyc;
        for (int k = 0; k < N; k++) send(k, 100, 0);
        check("ramp_cycles", cyc - c0, N);
        check("ramp_out_valid", out_valid, 1);
        check("ramp_ln_start", ln_start, 1);
        nerr = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (elem(r * 8 + c) != 8 * r + c + 100) nerr++;
        check("ramp_elems", nerr, 0);
        check("ramp_sat", sat_count, 0);
        step();
        check("ramp_ln_pulse_width", ln_start, 0);
        check("ramp_still_valid", out_valid, 1);
        take();

        // Saturation
        send(30000, 30000, 0);
        send(-30000, -30000, 0);
        send(32767, -1, 0);
        for (int k = 3; k < N; k++) send(0, 0, 0);
        check("sat_elem0", 64'(elem(0)), 64'(32767));
        check("sat_elem1", 64'(elem(1)), 64'(-32768));
        check("sat_elem2", 64'(elem(2)), 64'(32766));
        check("sat_count2", sat_count, 2);
        take();

        // Backpressure with a pending beat presented during hold
        send(-20000, -20000, 0);
        for (int k = 1; k < N; k++) send(int'($urandom_range(200, 0)) - 100, 5, 0);
        in_valid = 1'b1; in_a = 16'(7); in_b = 16'(8);
        repeat (10) begin
            step();
            check("bp_in_ready_low", in_ready, 0);
        end
        check("bp_sat_frozen", sat_count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_ready_after_take", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_next_elem0", 64'(elem(0)), 64'(15));
        check("bp_sat_restart", sat_count, 0);
        for (int k = 1; k < N; k++) send(int'($urandom), int'($urandom), 0);
        take();

        // Bursty random input with random out_ready delay
        for (int k = 0; k < N; k++) send(int'($urandom), int'($urandom), 2);
        repeat ($urandom_range(3, 0)) step();
        take();

        // Reset mid-fill
        for (int k = 0; k < 20; k++) send(int'($urandom), int'($urandom), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_sat", sat_count, 0);
        check("mid_rst_x_out", |x_out, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < N; k++) send(1, 1, 0);
        nerr = 0;
        for (int k = 0; k < N; k++) if (elem(k) != 2) nerr++;
        check("post_rst_all_two", nerr, 0);
        check("post_rst_sat", sat_count, 0);
        take();

        // Back-to-back with layer-norm model
        use_ln = 1;
        ln_runs = 0;
        for (int k = 0; k < 2 * N; k++) send(int'($urandom), int'($urandom), 2);
        t = 0;
        while ((ln_runs < 2 || out_valid) && t < 200) begin step(); t++; end
        check("ln_runs", ln_runs, 2);
        use_ln = 0;
        out_ready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
